rtype_pipe_core: RTL and testbench
==================================

Name: rtype_pipe_core

Overview:
- Parametrised successor to the single-cycle R-type datapath.
- Three-stage pipelined R-type execution core: decode/operand-read (D), execute (E), writeback (W).
- Adds selectable XLEN (RV32/RV64, with RV64 W-ops), a valid/ready instruction handshake, retire back-pressure, full E-to-D forwarding and illegal-instruction reporting.
- Sits between the instruction source and the retire/trace logic; owns the integer register file.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- NREG, 32, number of architectural registers; 16 (RV32E) or 32. Register addresses at or above NREG are illegal.
- RST_RF, 1, 1 = register file cleared to zero on rst; 0 = register file contents untouched by rst.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  core can accept an instruction.
- instruction  in  32  RISC-V instruction word.
- retire_valid  out  1  E-stage result available to retire.
- retire_ready  in  1  consumer accepts the retire.
- retire_rd  out  5  destination register of the retiring instruction.
- retire_data  out  XLEN  result value.
- retire_illegal  out  1  retiring instruction was illegal.
- dbg_addr  in  5  debug register-file read address.
- dbg_data  out  XLEN  combinational register-file read; x0 reads as 0.

Behaviour:
- Reset: one synchronous clock with rst=1 clears D_valid and E_valid.
  - Outputs after reset: instr_ready=1, retire_valid=0, retire_rd=0, retire_data=0, retire_illegal=0.
  - Register file cleared to zero if RST_RF=1.
  - rst mid-operation discards all in-flight instructions; no register write occurs on the reset edge.
- Handshake:
  - Accept when instr_valid && instr_ready at a rising edge.
  - Retire when retire_valid && retire_ready at a rising edge.
  - instr_ready = !D_valid || advance, where advance = !E_valid || retire_ready.
  - When retire_ready=0 and E_valid=1, both E and D hold their contents.
  - retire_* outputs stay stable while retire_valid=1 and retire_ready=0.
- Latency:
  - Instruction accepted at edge k enters E at edge k+1; retire_valid=1 during cycle k+1.
  - The register write happens at the retire edge; minimum latency 2 cycles.
  - Throughput is 1 instruction/cycle with retire_ready held at 1.
- D stage:
  - Decodes opcode, funct3 and funct7, then reads rs1 and rs2.
  - Bypass priority: E result if E_valid, E not illegal, E.rd == rs and rs != 0; otherwise the register file.
  - A write at the same edge is covered by the E bypass.
- Legal encodings:
  - opcode 0110011 with funct7 0000000 or 0100000: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - If XLEN=64, opcode 0111011: ADDW, SUBW, SLLW, SRLW, SRAW.
  - Everything else is illegal, including funct7 0100000 with funct3 other than 000 or 101, and any register address >= NREG.
- Illegal instructions:
  - Accepted and flow through the pipeline; retire with retire_illegal=1, retire_rd=0, retire_data=0.
  - No register write.
- Arithmetic:
  - Operations are modulo 2^XLEN.
  - Shift amount is rs2[log2(XLEN)-1:0].
  - SLT is signed and SLTU unsigned; both return 0 or 1.
  - W-ops operate on the low 32 bits with shamt = rs2[4:0], and the 32-bit result is sign-extended to 64.
- Writes to x0 are dropped; x0 always reads 0. retire_rd still reports 0 and retire_data reports the computed value.
- Simultaneous accept and retire in the same cycle is legal and is the normal streaming case.

Test Plan:
- Reset then streaming: rst 1 cycle, then ADD x1,x0,x0; ADD x2,x1,x1 → retire_valid in cycles 2 and 3, both retire_data=0, instr_ready stays 1.
- Forwarding: dbg-preload via ADD chain so x1=5 and x2=7; SUB x3,x1,x2 then immediately XOR x4,x3,x1 → x3 = 0xFFFFFFFE; x4 = 0xFFFFFFFE ^ 5 = 0xFFFFFFFB, obtained through the bypass.
- Back-pressure: retire_ready=0 for 3 cycles with 2 instructions in flight → instr_ready=0; retire_* stable; no register write; on release, both retire in order.
- Shifts and compares (XLEN=32): x1=0x80000000, x2=33 → SRA gives 0xC0000000 (shamt=1), SRL gives 0x40000000, SLT x1,x0 gives 1, SLTU gives 0.
- XLEN=64 W-ops: x1=0x00000000_7FFFFFFF, x2=1 → ADDW gives 0xFFFFFFFF_80000000, SRAW of that by 4 gives 0xFFFFFFFF_F8000000; with XLEN=32, opcode 0111011 → retire_illegal=1, no write.
- Illegal and x0: funct7 0100000 with funct3 001 → retire_illegal=1, x-regs unchanged; ADD x0,x1,x1 → dbg_addr=0 reads 0. Assert rst while 2 instructions are in flight → retire_valid=0 next cycle and no write.

Source files
------------

// File: rtl/rtype_pipe_core.sv
// Three-stage (decode/execute/writeback) RISC-V R-type core with RV64 W-ops,
// valid/ready instruction and retire handshakes, E-to-D forwarding and illegal reporting.
module rtype_pipe_core #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned RST_RF = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instruction,
    output logic            retire_valid,
    input  logic            retire_ready,
    output logic [4:0]      retire_rd,
    output logic [XLEN-1:0] retire_data,
    output logic            retire_illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
    localparam int unsigned SW = $clog2(XLEN);
    localparam int unsigned AW = $clog2(NREG);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_W    = 7'b0111011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic            r_d_valid;
    logic [31:0]     r_d_instr;
    logic            r_e_valid;
    logic [4:0]      r_e_rd;
    logic [XLEN-1:0] r_e_data;
    logic            r_e_illegal;
    logic [XLEN-1:0] r_rf [NREG];

    logic            w_advance;
    logic            w_accept;
    logic            w_rf_we;
    logic [6:0]      w_opcode;
    logic [6:0]      w_f7;
    logic [2:0]      w_f3;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_legal;
    logic            w_fwd1;
    logic            w_fwd2;
    logic [XLEN-1:0] w_rf1;
    logic [XLEN-1:0] w_rf2;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [31:0]     w_r32;
    logic [XLEN-1:0] w_result;

    assign w_advance   = !r_e_valid || retire_ready;
    assign instr_ready = !r_d_valid || w_advance;
    assign w_accept    = instr_valid && instr_ready;
    assign w_rf_we     = r_e_valid && retire_ready && !r_e_illegal && (r_e_rd != 5'd0);

    assign w_opcode = r_d_instr[6:0];
    assign w_rd     = r_d_instr[11:7];
    assign w_f3     = r_d_instr[14:12];
    assign w_rs1    = r_d_instr[19:15];
    assign w_rs2    = r_d_instr[24:20];
    assign w_f7     = r_d_instr[31:25];

    // Operand read: the E result shadows the register file (also covers a same-edge write).
    assign w_rf1  = (w_rs1 == 5'd0 || 32'(w_rs1) >= NREG) ? '0 : r_rf[w_rs1[AW-1:0]];
    assign w_rf2  = (w_rs2 == 5'd0 || 32'(w_rs2) >= NREG) ? '0 : r_rf[w_rs2[AW-1:0]];
    assign w_fwd1 = r_e_valid && !r_e_illegal && (w_rs1 != 5'd0) && (r_e_rd == w_rs1);
    assign w_fwd2 = r_e_valid && !r_e_illegal && (w_rs2 != 5'd0) && (r_e_rd == w_rs2);
    assign w_a    = w_fwd1 ? r_e_data : w_rf1;
    assign w_b    = w_fwd2 ? r_e_data : w_rf2;

    assign dbg_data = (dbg_addr == 5'd0 || 32'(dbg_addr) >= NREG) ? '0 : r_rf[dbg_addr[AW-1:0]];

    // Legality of the instruction held in D
    always_comb begin
        w_legal = 1'b0;
        if (w_opcode == OP_R) begin
            w_legal = (w_f7 == F7_BASE) ||
                      (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101));
        end else if (w_opcode == OP_W && XLEN == 64) begin
            w_legal = (w_f7 == F7_BASE && (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b101)) ||
                      (w_f7 == F7_ALT  && (w_f3 == 3'b000 || w_f3 == 3'b101));
        end
        if (32'(w_rd) >= NREG || 32'(w_rs1) >= NREG || 32'(w_rs2) >= NREG) begin
            w_legal = 1'b0;
        end
    end

    // Execute: full-width ops, or 32-bit W-ops sign-extended to XLEN
    always_comb begin
        w_result = '0;
        w_r32    = '0;
        if (w_opcode == OP_R) begin
            case (w_f3)
                3'b000:  w_result = w_f7[5] ? (w_a - w_b) : (w_a + w_b);
                3'b001:  w_result = w_a << w_b[SW-1:0];
                3'b010:  w_result = XLEN'($signed(w_a) < $signed(w_b));
                3'b011:  w_result = XLEN'(w_a < w_b);
                3'b100:  w_result = w_a ^ w_b;
                3'b101:  w_result = w_f7[5] ? XLEN'($signed(w_a) >>> w_b[SW-1:0])
                                            : (w_a >> w_b[SW-1:0]);
                3'b110:  w_result = w_a | w_b;
                default: w_result = w_a & w_b;
            endcase
        end else begin
            case (w_f3)
                3'b000:  w_r32 = w_f7[5] ? (w_a[31:0] - w_b[31:0]) : (w_a[31:0] + w_b[31:0]);
                3'b001:  w_r32 = w_a[31:0] << w_b[4:0];
                3'b101:  w_r32 = w_f7[5] ? 32'($signed(w_a[31:0]) >>> w_b[4:0])
                                         : (w_a[31:0] >> w_b[4:0]);
                default: w_r32 = '0;
            endcase
            w_result = XLEN'($signed(w_r32));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_valid   <= 1'b0;
            r_d_instr   <= '0;
            r_e_valid   <= 1'b0;
            r_e_rd      <= '0;
            r_e_data    <= '0;
            r_e_illegal <= 1'b0;
        end else begin
            if (w_advance) begin
                r_e_valid   <= r_d_valid;
                r_e_rd      <= (r_d_valid && w_legal) ? w_rd : 5'd0;
                r_e_data    <= (r_d_valid && w_legal) ? w_result : '0;
                r_e_illegal <= r_d_valid && !w_legal;
            end
            if (w_accept) begin
                r_d_valid <= 1'b1;
                r_d_instr <= instruction;
            end else if (w_advance) begin
                r_d_valid <= 1'b0;
            end
        end
    end

    // Register file: optionally cleared on reset, written at the retire edge
    always_ff @(posedge clk) begin
        if (rst) begin
            if (RST_RF != 0) begin
                for (int unsigned i = 0; i < NREG; i++) begin
                    r_rf[i] <= '0;
                end
            end
        end else if (w_rf_we) begin
            r_rf[r_e_rd[AW-1:0]] <= r_e_data;
        end
    end

    assign retire_valid   = r_e_valid;
    assign retire_rd      = r_e_rd;
    assign retire_data    = r_e_data;
    assign retire_illegal = r_e_illegal;
endmodule

// File: tb/tb_rtype_pipe_core.sv
// Bench for rtype_pipe_core: RV32 instance checked through a retire scoreboard,
// plus an RV64/RV32E instance with RST_RF=0 checked cycle by cycle.
module tb_rtype_pipe_core;
    localparam logic [6:0] OPR = 7'b0110011;
    localparam logic [6:0] OPW = 7'b0111011;
    localparam logic [6:0] F0  = 7'b0000000;
    localparam logic [6:0] FA  = 7'b0100000;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        exp_t        e;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] val;
    } rf_t;

    logic        clk = 1'b0;
    logic        rst, instr_valid, instr_ready, retire_valid, retire_ready, retire_illegal;
    logic [31:0] instruction, retire_data, dbg_data;
    logic [4:0]  retire_rd, dbg_addr;

    logic        rst_64, instr_valid_64, instr_ready_64, retire_valid_64, retire_illegal_64;
    logic        retire_ready_64;
    logic [31:0] instruction_64;
    logic [63:0] retire_data_64, dbg_data_64;
    logic [4:0]  retire_rd_64, dbg_addr_64;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[20];
    rf_t  rf_exp[10];

    always #5 clk = ~clk;

    rtype_pipe_core #(.XLEN(32), .NREG(32), .RST_RF(1)) u_dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
        .retire_valid(retire_valid), .retire_ready(retire_ready), .retire_rd(retire_rd),
        .retire_data(retire_data), .retire_illegal(retire_illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    rtype_pipe_core #(.XLEN(64), .NREG(16), .RST_RF(0)) u_dut64 (
        .clk(clk), .rst(rst_64),
        .instr_valid(instr_valid_64), .instr_ready(instr_ready_64), .instruction(instruction_64),
        .retire_valid(retire_valid_64), .retire_ready(retire_ready_64), .retire_rd(retire_rd_64),
        .retire_data(retire_data_64), .retire_illegal(retire_illegal_64),
        .dbg_addr(dbg_addr_64), .dbg_data(dbg_data_64)
    );

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] data, input logic ill);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        e.ill  = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic dbg_chk(input string name, input logic [4:0] a, input logic [31:0] e);
        dbg_addr = a;
        #1;
        chk(name, 64'(dbg_data), 64'(e));
    endtask

    task automatic dbg_chk64(input string name, input logic [4:0] a, input logic [63:0] e);
        dbg_addr_64 = a;
        #1;
        chk(name, dbg_data_64, e);
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction; its expected retire is queued at the accepting edge.
    task automatic send(input logic [31:0] ins, input exp_t e);
        instr_valid = 1'b1;
        instruction = ins;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                instr_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: instr_ready stayed 0 for ins %h", ins);
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && !retire_valid) return;
            align();
        end
        n_checks++;
        n_fail++;
        $display("FAIL drain_timeout: %0d retires still pending", exp_q.size());
    endtask

    // RV64 instance: one instruction at a time, latency checked each cycle.
    task automatic send64(input string name, input logic [31:0] ins, input logic [4:0] rd,
                          input logic [63:0] data, input logic ill);
        chk({name, "_ready"}, 64'(instr_ready_64), 64'd1);
        instr_valid_64 = 1'b1;
        instruction_64 = ins;
        align();
        instr_valid_64 = 1'b0;
        chk({name, "_lat0"}, 64'(retire_valid_64), 64'd0);
        align();
        chk({name, "_valid"}, 64'(retire_valid_64), 64'd1);
        chk({name, "_rd"}, 64'(retire_rd_64), 64'(rd));
        chk({name, "_data"}, retire_data_64, data);
        chk({name, "_ill"}, 64'(retire_illegal_64), 64'(ill));
        align();
    endtask

    // Scoreboard: compare each retire handshake against the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && retire_valid && retire_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_retire: rd=%0d data=%h", retire_rd, retire_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("retire_rd", 64'(retire_rd), 64'(mon_e.rd));
                chk("retire_data", 64'(retire_data), 64'(mon_e.data));
                chk("retire_illegal", 64'(retire_illegal), 64'(mon_e.ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{enc(FA, 3'b000, 5'd3,  5'd1,  5'd2,  OPR), mk(5'd3,  32'hFFFF_FFFE, 1'b0)};
        vecs[1]  = '{enc(F0, 3'b100, 5'd4,  5'd3,  5'd1,  OPR), mk(5'd4,  32'hFFFF_FFFB, 1'b0)};
        vecs[2]  = '{enc(F0, 3'b000, 5'd5,  5'd4,  5'd2,  OPR), mk(5'd5,  32'h0000_0002, 1'b0)};
        vecs[3]  = '{enc(F0, 3'b001, 5'd6,  5'd1,  5'd2,  OPR), mk(5'd6,  32'h0000_0280, 1'b0)};
        vecs[4]  = '{enc(F0, 3'b010, 5'd7,  5'd3,  5'd1,  OPR), mk(5'd7,  32'h0000_0001, 1'b0)};
        vecs[5]  = '{enc(F0, 3'b011, 5'd8,  5'd3,  5'd1,  OPR), mk(5'd8,  32'h0000_0000, 1'b0)};
        vecs[6]  = '{enc(F0, 3'b110, 5'd9,  5'd1,  5'd2,  OPR), mk(5'd9,  32'h0000_0007, 1'b0)};
        vecs[7]  = '{enc(F0, 3'b111, 5'd10, 5'd1,  5'd2,  OPR), mk(5'd10, 32'h0000_0005, 1'b0)};
        vecs[8]  = '{enc(FA, 3'b101, 5'd11, 5'd3,  5'd1,  OPR), mk(5'd11, 32'hFFFF_FFFF, 1'b0)};
        vecs[9]  = '{enc(F0, 3'b101, 5'd12, 5'd3,  5'd1,  OPR), mk(5'd12, 32'h07FF_FFFF, 1'b0)};
        vecs[10] = '{enc(F0, 3'b000, 5'd0,  5'd1,  5'd1,  OPR), mk(5'd0,  32'h0000_000A, 1'b0)};
        vecs[11] = '{enc(FA, 3'b000, 5'd15, 5'd0,  5'd1,  OPR), mk(5'd15, 32'hFFFF_FFFB, 1'b0)};
        vecs[12] = '{enc(FA, 3'b001, 5'd13, 5'd1,  5'd2,  OPR), mk(5'd0,  32'h0000_0000, 1'b1)};
        vecs[13] = '{enc(F0, 3'b000, 5'd14, 5'd1,  5'd2,  OPW), mk(5'd0,  32'h0000_0000, 1'b1)};
        vecs[14] = '{enc(7'b0000001, 3'b000, 5'd16, 5'd1, 5'd2, OPR), mk(5'd0, 32'h0, 1'b1)};
        vecs[15] = '{enc(FA, 3'b101, 5'd19, 5'd17, 5'd18, OPR), mk(5'd19, 32'hC000_0000, 1'b0)};
        vecs[16] = '{enc(F0, 3'b101, 5'd20, 5'd17, 5'd18, OPR), mk(5'd20, 32'h4000_0000, 1'b0)};
        vecs[17] = '{enc(F0, 3'b010, 5'd21, 5'd17, 5'd0,  OPR), mk(5'd21, 32'h0000_0001, 1'b0)};
        vecs[18] = '{enc(F0, 3'b011, 5'd22, 5'd17, 5'd0,  OPR), mk(5'd22, 32'h0000_0000, 1'b0)};
        vecs[19] = '{enc(F0, 3'b001, 5'd23, 5'd18, 5'd18, OPR), mk(5'd23, 32'h0000_0042, 1'b0)};

        rf_exp[0] = '{5'd3,  32'hFFFF_FFFE};
        rf_exp[1] = '{5'd4,  32'hFFFF_FFFB};
        rf_exp[2] = '{5'd5,  32'h0000_0002};
        rf_exp[3] = '{5'd12, 32'h07FF_FFFF};
        rf_exp[4] = '{5'd13, 32'h0000_0000};
        rf_exp[5] = '{5'd14, 32'h0000_0000};
        rf_exp[6] = '{5'd16, 32'h0000_0000};
        rf_exp[7] = '{5'd0,  32'h0000_0000};
        rf_exp[8] = '{5'd19, 32'hC000_0000};
        rf_exp[9] = '{5'd1,  32'h0000_0005};

        rst = 1'b1;            rst_64 = 1'b1;
        instr_valid = 1'b0;    instr_valid_64 = 1'b0;
        instruction = '0;      instruction_64 = '0;
        retire_ready = 1'b1;   retire_ready_64 = 1'b1;
        dbg_addr = '0;         dbg_addr_64 = '0;
        align();
        rst = 1'b0;
        rst_64 = 1'b0;

        // Reset state
        chk("rst_instr_ready", 64'(instr_ready), 64'd1);
        chk("rst_retire_valid", 64'(retire_valid), 64'd0);
        chk("rst_retire_rd", 64'(retire_rd), 64'd0);
        chk("rst_retire_data", 64'(retire_data), 64'd0);
        chk("rst_retire_illegal", 64'(retire_illegal), 64'd0);
        dbg_chk("rst_rf_x5", 5'd5, 32'h0);
        align();

        // Back-to-back streaming straight out of reset
        send(enc(F0, 3'b000, 5'd1, 5'd0, 5'd0, OPR), mk(5'd1, 32'h0, 1'b0));
        send(enc(F0, 3'b000, 5'd2, 5'd1, 5'd1, OPR), mk(5'd2, 32'h0, 1'b0));
        chk("stream_instr_ready", 64'(instr_ready), 64'd1);
        chk("stream_retire_valid", 64'(retire_valid), 64'd1);
        drain();

        u_dut.r_rf[1]  = 32'd5;
        u_dut.r_rf[2]  = 32'd7;
        u_dut.r_rf[17] = 32'h8000_0000;
        u_dut.r_rf[18] = 32'd33;

        // Vector table streamed back to back, exercising forwarding
        foreach (vecs[i]) send(vecs[i].ins, vecs[i].e);
        drain();
        foreach (rf_exp[i]) dbg_chk($sformatf("rf_x%0d", rf_exp[i].addr), rf_exp[i].addr, rf_exp[i].val);
        align();

        // Back-pressure with two instructions in flight
        retire_ready = 1'b0;
        send(enc(F0, 3'b000, 5'd24, 5'd1, 5'd2, OPR), mk(5'd24, 32'd12, 1'b0));
        send(enc(F0, 3'b100, 5'd25, 5'd24, 5'd1, OPR), mk(5'd25, 32'd9, 1'b0));
        for (int c = 0; c < 3; c++) begin
            chk("bp_instr_ready", 64'(instr_ready), 64'd0);
            chk("bp_retire_valid", 64'(retire_valid), 64'd1);
            chk("bp_retire_rd", 64'(retire_rd), 64'd24);
            chk("bp_retire_data", 64'(retire_data), 64'd12);
            dbg_chk("bp_no_write_x24", 5'd24, 32'h0);
            align();
        end
        retire_ready = 1'b1;
        drain();
        dbg_chk("bp_x24", 5'd24, 32'd12);
        dbg_chk("bp_x25", 5'd25, 32'd9);
        align();

        // Reset with two instructions in flight, retire_ready high at the reset edge
        retire_ready = 1'b0;
        send(enc(F0, 3'b000, 5'd26, 5'd1, 5'd1, OPR), mk(5'd26, 32'd10, 1'b0));
        send(enc(F0, 3'b000, 5'd27, 5'd1, 5'd2, OPR), mk(5'd27, 32'd12, 1'b0));
        rst = 1'b1;
        retire_ready = 1'b1;
        align();
        rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_retire_valid", 64'(retire_valid), 64'd0);
        chk("mid_rst_instr_ready", 64'(instr_ready), 64'd1);
        chk("mid_rst_retire_data", 64'(retire_data), 64'd0);
        dbg_chk("mid_rst_x26", 5'd26, 32'h0);
        dbg_chk("mid_rst_x1_cleared", 5'd1, 32'h0);
        align();

        // RV64 W-ops, RV32E register limit and RST_RF=0
        u_dut64.r_rf[1] = 64'h0000_0000_7FFF_FFFF;
        u_dut64.r_rf[2] = 64'd1;
        u_dut64.r_rf[4] = 64'd4;
        send64("addw",  enc(F0, 3'b000, 5'd3, 5'd1, 5'd2, OPW), 5'd3, 64'hFFFF_FFFF_8000_0000, 1'b0);
        send64("sraw",  enc(FA, 3'b101, 5'd5, 5'd3, 5'd4, OPW), 5'd5, 64'hFFFF_FFFF_F800_0000, 1'b0);
        send64("add64", enc(F0, 3'b000, 5'd6, 5'd1, 5'd2, OPR), 5'd6, 64'h0000_0000_8000_0000, 1'b0);
        send64("srlw",  enc(F0, 3'b101, 5'd7, 5'd3, 5'd2, OPW), 5'd7, 64'h0000_0000_4000_0000, 1'b0);
        send64("sllw",  enc(F0, 3'b001, 5'd8, 5'd1, 5'd2, OPW), 5'd8, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        send64("subw",  enc(FA, 3'b000, 5'd9, 5'd0, 5'd2, OPW), 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send64("srl64", enc(F0, 3'b101, 5'd10, 5'd3, 5'd4, OPR), 5'd10, 64'h0FFF_FFFF_F800_0000, 1'b0);
        send64("rd16",  enc(F0, 3'b000, 5'd16, 5'd1, 5'd2, OPR), 5'd0, 64'h0, 1'b1);
        send64("rs20",  enc(F0, 3'b000, 5'd11, 5'd20, 5'd2, OPR), 5'd0, 64'h0, 1'b1);
        send64("sllw_alt", enc(FA, 3'b001, 5'd12, 5'd1, 5'd2, OPW), 5'd0, 64'h0, 1'b1);
        dbg_chk64("rv64_x3", 5'd3, 64'hFFFF_FFFF_8000_0000);
        dbg_chk64("rv64_x5", 5'd5, 64'hFFFF_FFFF_F800_0000);
        align();

        instr_valid_64 = 1'b1;
        instruction_64 = enc(F0, 3'b000, 5'd1, 5'd2, 5'd2, OPR);
        align();
        instr_valid_64 = 1'b0;
        align();
        rst_64 = 1'b1;
        align();
        rst_64 = 1'b0;
        chk("rv64_rst_retire_valid", 64'(retire_valid_64), 64'd0);
        dbg_chk64("rv64_rst_no_write_x1", 5'd1, 64'h0000_0000_7FFF_FFFF);
        dbg_chk64("rv64_rst_kept_x3", 5'd3, 64'hFFFF_FFFF_8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
